// File: rtl/coretse_ahb_dma_arbiter.sv
// ---------------------------------------------------------------------------
// coretse_ahb_dma_arbiter
//
// This block shares one system AHB master port between the CoreTSE transmit
// DMA master (TXH*) and the receive DMA master (RXH*). It contains:
//   - A registered grant FSM (IDLE / GNT_TX / GNT_RX). Ties are broken by
//     round-robin, or always go to RX when RX_FIXED_PRIO=1. A locked owner
//     keeps the grant.
//   - An address-phase owner (HMASTER) and a data-phase owner. Both advance
//     only on HREADY edges.
//   - Zero-latency multiplexers for the address, control and write-data
//     paths. Responses are fanned out to both masters.
//   - Per-master saturating wait counters with sticky starve flags. A set
//     and a STARVE_CLR on the same edge resolve in favour of the set.
//
// Ports
//   HCLK, HRESETN          clock, asynchronous active-low reset
//   TX*/RX* H* inputs      request, lock and address-phase fields, write data
//   TXHGRANT/RXHGRANT      registered grants
//   TX/RX HREADY/HRESP/HRDATA  copies of the fabric response
//   M_H*                   shared master port to the fabric
//   HMASTER                address owner: 00 none, 01 TX, 10 RX
//   TX_STARVE/RX_STARVE    sticky starve flags; STARVE_CLR clears both
// ---------------------------------------------------------------------------
module coretse_ahb_dma_arbiter #(
  parameter int RX_FIXED_PRIO = 0,
  parameter int MAX_WAIT      = 64
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        TXHBUSREQ,
  input  logic        RXHBUSREQ,
  input  logic        TXHLOCK,
  input  logic        RXHLOCK,
  input  logic [1:0]  TXHTRANS,
  input  logic [1:0]  RXHTRANS,
  input  logic [31:0] TXHADDR,
  input  logic [31:0] RXHADDR,
  input  logic        TXHWRITE,
  input  logic        RXHWRITE,
  input  logic [2:0]  TXHSIZE,
  input  logic [2:0]  RXHSIZE,
  input  logic [2:0]  TXHBURST,
  input  logic [2:0]  RXHBURST,
  input  logic [31:0] TXHWDATA,
  input  logic [31:0] RXHWDATA,
  output logic        TXHGRANT,
  output logic        RXHGRANT,
  output logic        TXHREADY,
  output logic        RXHREADY,
  output logic [1:0]  TXHRESP,
  output logic [1:0]  RXHRESP,
  output logic [31:0] TXHRDATA,
  output logic [31:0] RXHRDATA,
  output logic [1:0]  M_HTRANS,
  output logic [31:0] M_HADDR,
  output logic        M_HWRITE,
  output logic [2:0]  M_HSIZE,
  output logic [2:0]  M_HBURST,
  output logic [31:0] M_HWDATA,
  output logic        M_HMASTLOCK,
  input  logic        M_HREADY,
  input  logic [1:0]  M_HRESP,
  input  logic [31:0] M_HRDATA,
  output logic [1:0]  HMASTER,
  output logic        TX_STARVE,
  output logic        RX_STARVE,
  input  logic        STARVE_CLR
);

  localparam logic       LP_RX_PRIO = (RX_FIXED_PRIO != 0);
  localparam logic [9:0] LP_MAX     = 10'(MAX_WAIT);
  localparam logic [9:0] LP_SAT     = 10'h3FF;

  typedef enum logic [1:0] {ST_IDLE, ST_GNT_TX, ST_GNT_RX} state_t;

  state_t      r_state;
  logic        r_txgnt, r_rxgnt;
  logic        r_last_rx;        // 1 when RX was the most recent grant
  logic [1:0]  r_hmaster;        // address-phase owner
  logic [1:0]  r_dmaster;        // data-phase owner
  logic [9:0]  r_tx_cnt, r_rx_cnt;
  logic        r_tx_starve, r_rx_starve;

  logic        w_tx_rel, w_rx_rel, w_idle_pick_rx;
  logic [9:0]  w_tx_cnt_nxt, w_rx_cnt_nxt;

  // An owner releases only when it is neither requesting nor locked.
  assign w_tx_rel = !TXHBUSREQ && !TXHLOCK;
  assign w_rx_rel = !RXHBUSREQ && !RXHLOCK;

  // From IDLE, RX wins when it requests alone, or on a tie when RX has fixed
  // priority or TX was granted last.
  assign w_idle_pick_rx = RXHBUSREQ && (!TXHBUSREQ || LP_RX_PRIO || !r_last_rx);

  // ---------------------------------------------------------------- grant FSM
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state   <= ST_IDLE;
      r_txgnt   <= 1'b0;
      r_rxgnt   <= 1'b0;
      r_last_rx <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_idle_pick_rx) begin
            r_state <= ST_GNT_RX; r_rxgnt <= 1'b1; r_txgnt <= 1'b0; r_last_rx <= 1'b1;
          end else if (TXHBUSREQ) begin
            r_state <= ST_GNT_TX; r_txgnt <= 1'b1; r_rxgnt <= 1'b0; r_last_rx <= 1'b0;
          end
        end
        ST_GNT_TX: begin
          if (w_tx_rel) begin
            if (RXHBUSREQ) begin
              r_state <= ST_GNT_RX; r_rxgnt <= 1'b1; r_txgnt <= 1'b0; r_last_rx <= 1'b1;
            end else begin
              r_state <= ST_IDLE; r_txgnt <= 1'b0; r_rxgnt <= 1'b0;
            end
          end
        end
        ST_GNT_RX: begin
          if (w_rx_rel) begin
            if (TXHBUSREQ) begin
              r_state <= ST_GNT_TX; r_txgnt <= 1'b1; r_rxgnt <= 1'b0; r_last_rx <= 1'b0;
            end else begin
              r_state <= ST_IDLE; r_txgnt <= 1'b0; r_rxgnt <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE; r_txgnt <= 1'b0; r_rxgnt <= 1'b0;
        end
      endcase
    end
  end

  assign TXHGRANT = r_txgnt;
  assign RXHGRANT = r_rxgnt;

  // --------------------------------------------------------- bus ownership
  // A grant becomes address ownership only on an HREADY edge. The data
  // owner trails the address owner by one completed address phase.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_hmaster <= 2'b00;
      r_dmaster <= 2'b00;
    end else if (M_HREADY) begin
      r_hmaster <= {r_rxgnt, r_txgnt};
      r_dmaster <= r_hmaster;
    end
  end

  assign HMASTER = r_hmaster;

  // ------------------------------------------------------------ multiplexers
  always_comb begin
    M_HTRANS    = 2'b00;
    M_HADDR     = 32'h0;
    M_HWRITE    = 1'b0;
    M_HSIZE     = 3'b000;
    M_HBURST    = 3'b000;
    M_HMASTLOCK = 1'b0;
    case (r_hmaster)
      2'b01: begin
        M_HTRANS = TXHTRANS; M_HADDR  = TXHADDR;  M_HWRITE    = TXHWRITE;
        M_HSIZE  = TXHSIZE;  M_HBURST = TXHBURST; M_HMASTLOCK = TXHLOCK;
      end
      2'b10: begin
        M_HTRANS = RXHTRANS; M_HADDR  = RXHADDR;  M_HWRITE    = RXHWRITE;
        M_HSIZE  = RXHSIZE;  M_HBURST = RXHBURST; M_HMASTLOCK = RXHLOCK;
      end
      default: ;
    endcase
  end

  always_comb begin
    M_HWDATA = 32'h0;
    case (r_dmaster)
      2'b01:   M_HWDATA = TXHWDATA;
      2'b10:   M_HWDATA = RXHWDATA;
      default: ;
    endcase
  end

  // The response goes to both masters. Each master qualifies it with its
  // own ownership history.
  assign TXHREADY = M_HREADY;
  assign RXHREADY = M_HREADY;
  assign TXHRESP  = M_HRESP;
  assign RXHRESP  = M_HRESP;
  assign TXHRDATA = M_HRDATA;
  assign RXHRDATA = M_HRDATA;

  // -------------------------------------------------------- starvation watch
  assign w_tx_cnt_nxt = (r_txgnt || !TXHBUSREQ) ? 10'd0 :
                        (r_tx_cnt == LP_SAT) ? r_tx_cnt : r_tx_cnt + 10'd1;
  assign w_rx_cnt_nxt = (r_rxgnt || !RXHBUSREQ) ? 10'd0 :
                        (r_rx_cnt == LP_SAT) ? r_rx_cnt : r_rx_cnt + 10'd1;

  // The set condition is re-evaluated on every edge while the master is still
  // waiting. A clear therefore cannot take effect until the wait ends.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_tx_cnt    <= 10'd0;
      r_rx_cnt    <= 10'd0;
      r_tx_starve <= 1'b0;
      r_rx_starve <= 1'b0;
    end else begin
      r_tx_cnt <= w_tx_cnt_nxt;
      r_rx_cnt <= w_rx_cnt_nxt;
      if (w_tx_cnt_nxt >= LP_MAX) r_tx_starve <= 1'b1;
      else if (STARVE_CLR)        r_tx_starve <= 1'b0;
      if (w_rx_cnt_nxt >= LP_MAX) r_rx_starve <= 1'b1;
      else if (STARVE_CLR)        r_rx_starve <= 1'b0;
    end
  end

  assign TX_STARVE = r_tx_starve;
  assign RX_STARVE = r_rx_starve;

endmodule

// File: tb/tb_coretse_ahb_dma_arbiter.sv
module tb_coretse_ahb_dma_arbiter;
  logic        HCLK = 1'b0, HRESETN;
  logic        TXHBUSREQ, RXHBUSREQ, TXHLOCK, RXHLOCK;
  logic [1:0]  TXHTRANS, RXHTRANS;
  logic [31:0] TXHADDR, RXHADDR, TXHWDATA, RXHWDATA;
  logic        TXHWRITE, RXHWRITE;
  logic [2:0]  TXHSIZE, RXHSIZE, TXHBURST, RXHBURST;
  logic        TXHGRANT, RXHGRANT, TXHREADY, RXHREADY;
  logic [1:0]  TXHRESP, RXHRESP;
  logic [31:0] TXHRDATA, RXHRDATA;
  logic [1:0]  M_HTRANS;
  logic [31:0] M_HADDR, M_HWDATA;
  logic        M_HWRITE, M_HMASTLOCK, M_HREADY;
  logic [2:0]  M_HSIZE, M_HBURST;
  logic [1:0]  M_HRESP;
  logic [31:0] M_HRDATA;
  logic [1:0]  HMASTER;
  logic        TX_STARVE, RX_STARVE, STARVE_CLR;

  int total = 0;
  int bad   = 0;

  coretse_ahb_dma_arbiter #(.RX_FIXED_PRIO(0), .MAX_WAIT(8)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .TXHBUSREQ(TXHBUSREQ), .RXHBUSREQ(RXHBUSREQ), .TXHLOCK(TXHLOCK), .RXHLOCK(RXHLOCK),
    .TXHTRANS(TXHTRANS), .RXHTRANS(RXHTRANS), .TXHADDR(TXHADDR), .RXHADDR(RXHADDR),
    .TXHWRITE(TXHWRITE), .RXHWRITE(RXHWRITE), .TXHSIZE(TXHSIZE), .RXHSIZE(RXHSIZE),
    .TXHBURST(TXHBURST), .RXHBURST(RXHBURST), .TXHWDATA(TXHWDATA), .RXHWDATA(RXHWDATA),
    .TXHGRANT(TXHGRANT), .RXHGRANT(RXHGRANT), .TXHREADY(TXHREADY), .RXHREADY(RXHREADY),
    .TXHRESP(TXHRESP), .RXHRESP(RXHRESP), .TXHRDATA(TXHRDATA), .RXHRDATA(RXHRDATA),
    .M_HTRANS(M_HTRANS), .M_HADDR(M_HADDR), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA), .M_HMASTLOCK(M_HMASTLOCK),
    .M_HREADY(M_HREADY), .M_HRESP(M_HRESP), .M_HRDATA(M_HRDATA),
    .HMASTER(HMASTER), .TX_STARVE(TX_STARVE), .RX_STARVE(RX_STARVE), .STARVE_CLR(STARVE_CLR)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic idle_inputs();
    TXHBUSREQ = 0; RXHBUSREQ = 0; TXHLOCK = 0; RXHLOCK = 0;
    TXHTRANS = 0; RXHTRANS = 0; TXHADDR = 0; RXHADDR = 0;
    TXHWRITE = 0; RXHWRITE = 0; TXHSIZE = 0; RXHSIZE = 0;
    TXHBURST = 0; RXHBURST = 0; TXHWDATA = 0; RXHWDATA = 0;
    STARVE_CLR = 0;
  endtask

  task automatic test_reset();
    HRESETN = 0; M_HREADY = 1; M_HRESP = 2'b00; M_HRDATA = 32'h1234_5678;
    idle_inputs();
    #12;
    total++; if ({TXHGRANT, RXHGRANT} !== 2'b00) begin bad++; $display("FAIL reset_grants got=%b want=00", {TXHGRANT, RXHGRANT}); end
    total++; if (HMASTER !== 2'b00) begin bad++; $display("FAIL reset_hmaster got=%b want=00", HMASTER); end
    total++; if ({M_HTRANS, M_HADDR, M_HWRITE, M_HSIZE, M_HBURST, M_HMASTLOCK, M_HWDATA} !== '0) begin
      bad++; $display("FAIL reset_mport got trans=%b addr=%h wdata=%h want all 0", M_HTRANS, M_HADDR, M_HWDATA); end
    total++; if ({TX_STARVE, RX_STARVE} !== 2'b00) begin bad++; $display("FAIL reset_starve got=%b want=00", {TX_STARVE, RX_STARVE}); end
    total++; if (TXHRDATA !== 32'h1234_5678 || RXHREADY !== 1'b1) begin bad++; $display("FAIL resp_fanout got=%h want=12345678", TXHRDATA); end
    @(posedge HCLK); #1 HRESETN = 1;
  endtask

  task automatic test_tie();
    TXHBUSREQ = 1; RXHBUSREQ = 1; tick();
    total++; if ({TXHGRANT, RXHGRANT} !== 2'b01) begin bad++; $display("FAIL tie1_rx_first got tx,rx=%b want 01", {TXHGRANT, RXHGRANT}); end
    RXHBUSREQ = 0; tick();
    total++; if ({TXHGRANT, RXHGRANT} !== 2'b10) begin bad++; $display("FAIL tie1_tx_on_release got tx,rx=%b want 10", {TXHGRANT, RXHGRANT}); end
    // Hand the bus back to RX so that RX becomes the most recent grant.
    TXHBUSREQ = 0; RXHBUSREQ = 1; tick();
    total++; if ({TXHGRANT, RXHGRANT} !== 2'b01) begin bad++; $display("FAIL tx_to_rx got tx,rx=%b want 01", {TXHGRANT, RXHGRANT}); end
    RXHBUSREQ = 0; tick();
    total++; if ({TXHGRANT, RXHGRANT} !== 2'b00) begin bad++; $display("FAIL back_to_idle got tx,rx=%b want 00", {TXHGRANT, RXHGRANT}); end
    TXHBUSREQ = 1; RXHBUSREQ = 1; tick();
    total++; if ({TXHGRANT, RXHGRANT} !== 2'b10) begin bad++; $display("FAIL tie2_tx_first got tx,rx=%b want 10", {TXHGRANT, RXHGRANT}); end
    TXHBUSREQ = 0; RXHBUSREQ = 0; tick(); tick(); tick(); tick();
    total++; if ({TXHGRANT, RXHGRANT, HMASTER} !== 4'b0000) begin bad++; $display("FAIL tie_settle got=%b want 0000", {TXHGRANT, RXHGRANT, HMASTER}); end
  endtask

  task automatic test_single_tx();
    logic [31:0] d [4];
    logic [31:0] base;
    base = 32'h2000_0000;
    for (int i = 0; i < 4; i++) d[i] = 32'hA000_0000 + i;
    TXHBUSREQ = 1; tick();
    total++; if (TXHGRANT !== 1'b1 || HMASTER !== 2'b00) begin bad++; $display("FAIL tx_grant got gnt=%b hm=%b want 1/00", TXHGRANT, HMASTER); end
    tick();
    total++; if (HMASTER !== 2'b01) begin bad++; $display("FAIL tx_hmaster got=%b want 01", HMASTER); end
    for (int i = 0; i < 4; i++) begin
      TXHTRANS = (i == 0) ? 2'b10 : 2'b11; TXHADDR = base + 32'(4 * i);
      TXHWRITE = 1; TXHSIZE = 3'b010; TXHBURST = 3'b011;
      TXHWDATA = (i == 0) ? 32'hDEAD_BEEF : d[i-1];
      if (i == 3) TXHBUSREQ = 0;
      #1;
      total++; if (M_HTRANS !== TXHTRANS || M_HADDR !== base + 32'(4 * i) || M_HBURST !== 3'b011) begin
        bad++; $display("FAIL tx_beat%0d got trans=%b addr=%h want %b/%h", i, M_HTRANS, M_HADDR, TXHTRANS, base + 32'(4 * i)); end
      total++; if (M_HWDATA !== ((i == 0) ? 32'h0 : d[i-1])) begin
        bad++; $display("FAIL tx_wdata%0d got=%h", i, M_HWDATA); end
      tick();
    end
    total++; if (TXHGRANT !== 1'b0) begin bad++; $display("FAIL tx_release got=%b want 0", TXHGRANT); end
    TXHTRANS = 0; TXHWDATA = d[3]; #1;
    total++; if (M_HWDATA !== d[3]) begin bad++; $display("FAIL tx_last_wdata got=%h want %h", M_HWDATA, d[3]); end
    tick();
    total++; if (HMASTER !== 2'b00 || M_HTRANS !== 2'b00) begin bad++; $display("FAIL tx_idle got hm=%b trans=%b want 00/00", HMASTER, M_HTRANS); end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_lock();
    RXHBUSREQ = 1; RXHLOCK = 1; tick();
    total++; if (RXHGRANT !== 1'b1) begin bad++; $display("FAIL lock_grant got=%b want 1", RXHGRANT); end
    tick();
    RXHTRANS = 2'b10; RXHADDR = 32'h3000_0040; RXHBUSREQ = 0; TXHBUSREQ = 1; #1;
    total++; if (M_HMASTLOCK !== 1'b1 || M_HADDR !== 32'h3000_0040) begin
      bad++; $display("FAIL lock_mastlock got lock=%b addr=%h want 1/30000040", M_HMASTLOCK, M_HADDR); end
    for (int k = 0; k < 3; k++) begin
      tick(); RXHTRANS = 2'b11;
      total++; if ({TXHGRANT, RXHGRANT, M_HMASTLOCK} !== 3'b011) begin
        bad++; $display("FAIL lock_hold%0d got tx,rx,lock=%b want 011", k, {TXHGRANT, RXHGRANT, M_HMASTLOCK}); end
    end
    RXHLOCK = 0; RXHTRANS = 0; tick();
    total++; if ({TXHGRANT, RXHGRANT} !== 2'b10) begin bad++; $display("FAIL lock_handover got tx,rx=%b want 10", {TXHGRANT, RXHGRANT}); end
    tick();
    total++; if (HMASTER !== 2'b01) begin bad++; $display("FAIL lock_hmaster got=%b want 01", HMASTER); end
    idle_inputs(); tick(); tick(); tick();
  endtask

  task automatic test_wait_handover();
    TXHBUSREQ = 1; tick(); tick();
    TXHTRANS = 2'b10; TXHWRITE = 1; TXHADDR = 32'h2000_0100; tick();
    TXHTRANS = 0; TXHWDATA = 32'h5A5A_1234; M_HREADY = 0; TXHBUSREQ = 0; RXHBUSREQ = 1; #1;
    total++; if (M_HWDATA !== 32'h5A5A_1234) begin bad++; $display("FAIL ws_wdata_pre got=%h want 5a5a1234", M_HWDATA); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (HMASTER !== 2'b01 || M_HWDATA !== 32'h5A5A_1234 || RXHGRANT !== 1'b1) begin
        bad++; $display("FAIL ws_hold%0d got hm=%b wdata=%h rxgnt=%b want 01/5a5a1234/1", k, HMASTER, M_HWDATA, RXHGRANT); end
    end
    M_HREADY = 1; tick();
    total++; if (HMASTER !== 2'b10 || M_HWDATA !== 32'h5A5A_1234) begin
      bad++; $display("FAIL ws_switch got hm=%b wdata=%h want 10/5a5a1234", HMASTER, M_HWDATA); end
    idle_inputs(); tick(); tick(); tick();
  endtask

  task automatic test_starve();
    STARVE_CLR = 1; tick(); STARVE_CLR = 0;
    TXHBUSREQ = 1; TXHLOCK = 1; tick();
    RXHBUSREQ = 1;
    for (int k = 0; k < 7; k++) tick();
    total++; if (RX_STARVE !== 1'b0) begin bad++; $display("FAIL starve_early got=%b want 0", RX_STARVE); end
    tick();
    total++; if (RX_STARVE !== 1'b1 || TX_STARVE !== 1'b0) begin bad++; $display("FAIL starve_set got rx,tx=%b%b want 10", RX_STARVE, TX_STARVE); end
    STARVE_CLR = 1; tick(); STARVE_CLR = 0;
    total++; if (RX_STARVE !== 1'b1) begin bad++; $display("FAIL starve_set_wins got=%b want 1", RX_STARVE); end
    TXHBUSREQ = 0; TXHLOCK = 0; tick();
    total++; if (RXHGRANT !== 1'b1 || RX_STARVE !== 1'b1) begin bad++; $display("FAIL starve_grant got gnt=%b st=%b want 1/1", RXHGRANT, RX_STARVE); end
    STARVE_CLR = 1; tick(); STARVE_CLR = 0;
    total++; if (RX_STARVE !== 1'b0) begin bad++; $display("FAIL starve_clear got=%b want 0", RX_STARVE); end
    idle_inputs(); tick(); tick(); tick();
  endtask

  task automatic test_async_reset();
    TXHBUSREQ = 1; TXHLOCK = 1; tick();
    RXHBUSREQ = 1;
    for (int k = 0; k < 9; k++) tick();
    TXHTRANS = 2'b10; TXHADDR = 32'h2000_0200; #1;
    total++; if (M_HTRANS !== 2'b10 || RX_STARVE !== 1'b1 || HMASTER !== 2'b01) begin
      bad++; $display("FAIL arst_pre got trans=%b st=%b hm=%b want 10/1/01", M_HTRANS, RX_STARVE, HMASTER); end
    #2 HRESETN = 0;
    #1;
    total++; if ({TXHGRANT, RXHGRANT, HMASTER, M_HTRANS, TX_STARVE, RX_STARVE} !== 8'h00) begin
      bad++; $display("FAIL arst_now got gnt=%b%b hm=%b trans=%b st=%b%b want all 0",
                      TXHGRANT, RXHGRANT, HMASTER, M_HTRANS, TX_STARVE, RX_STARVE); end
    total++; if (M_HADDR !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h want 0", M_HADDR); end
    idle_inputs(); tick(); HRESETN = 1; tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_tx();
    test_lock();
    test_wait_handover();
    test_starve();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
